alu_exec_unit: RTL and testbench

// - Execute-stage ALU directly downstream of the instruction-to-ALU-op translator; consumes its 4-bit alu_op plus two 32-bit operands.
// - Valid/ready in, valid/ready out, one registered result.
// - Non-shift ops take 1 cycle. Shifts iterate 1 bit/cycle unless the fast-shift option is compiled in.

---
 rtl/alu_exec_unit.sv | 133 +++++++++++++
 tb/tb_alu_exec_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes and a registered result.
// Shifts iterate one bit per cycle unless ALU_FAST_SHIFT_EN is defined, which selects a barrel shifter.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int SW = $clog2(XLEN);

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FastShift = 1'b1;
`else
    localparam bit FastShift = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q;
    logic [XLEN-1:0] result_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [SW-1:0]   cnt_q;
    logic [3:0]      op_q;

    logic            accept;
    logic [SW-1:0]   shamt;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == 4'b0100) || (op == 4'b0110) || (op == 4'b0111);
    endfunction

    function automatic logic [XLEN-1:0] shift1(input logic [3:0] op, input logic [XLEN-1:0] v);
        case (op)
            4'b0100: return {v[XLEN-2:0], 1'b0};
            4'b0110: return {1'b0, v[XLEN-1:1]};
            default: return {v[XLEN-1], v[XLEN-1:1]};
        endcase
    endfunction

    function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
        logic signed [XLEN-1:0] xs;
        logic signed [XLEN-1:0] ys;
        logic [SW-1:0]          sh;
        xs = x;
        ys = y;
        sh = y[SW-1:0];
        case (op)
            4'b0001: return x - y;
            4'b0100: return x << sh;
            4'b0110: return x >> sh;
            4'b0111: return xs >>> sh;
            4'b1001: return x & y;
            4'b1010: return x | y;
            4'b1011: return x ^ y;
            4'b1100: return {{(XLEN-1){1'b0}}, (x < y)};
            4'b1101: return {{(XLEN-1){1'b0}}, (xs < ys)};
            default: return x + y;
        endcase
    endfunction

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign shamt  = b[SW-1:0];

    // The first bit of an iterative shift is applied on the accept edge so latency equals shamt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            op_q        <= '0;
        end else begin
            case (state_q)
                SHIFT: begin
                    result_q <= shift1(op_q, result_q);
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == SW'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        op_q <= alu_op;
                        if (!FastShift && is_shift_op(alu_op) && (shamt > SW'(1))) begin
                            result_q    <= shift1(alu_op, a);
                            cnt_q       <= shamt - 1'b1;
                            state_q     <= SHIFT;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else begin
                            result_q    <= alu_f(alu_op, a, b);
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end else if ((state_q == DONE) && out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign busy      = FastShift ? 1'b0 : busy_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; honours ALU_FAST_SHIFT_EN for expected shift latency.
module tb_alu_exec_unit;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks;
    int failures;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .alu_op(alu_op),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one op for a single accept edge, then scrambles the operand bus.
    task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        in_valid = 1'b1;
        alu_op   = op;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_op   = 4'b1011;
        a        = 32'hDEAD_BEEF;
        b        = 32'h0000_0003;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = 4'b0000;
        a         = 32'h0;
        b         = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", result); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_arith();
        vec_t v [12];
        v = '{
            '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1},
            '{4'b0001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1},
            '{4'b1101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1},
            '{4'b1100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1},
            '{4'b1101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1},
            '{4'b1100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1},
            '{4'b1001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1},
            '{4'b1010, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1},
            '{4'b1011, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 1},
            '{4'b0010, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1},
            '{4'b1111, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1},
            '{4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1}
        };
        for (int i = 0; i < 12; i++) begin
            issue(v[i].op, v[i].a, v[i].b);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arith%0d_valid: got %b expected 1", i, out_valid); end
            checks++; if (result !== v[i].exp) begin failures++; $display("FAIL arith%0d_result: got %h expected %h", i, result, v[i].exp); end
            @(posedge clk);
            #1;
            if (i == 0) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arith_idle_valid: got %b expected 0", out_valid); end
            end
        end
    endtask

    task automatic test_shift();
        vec_t v [7];
        int   lat;
        int   exp_lat;
        logic hold_ok;
        v = '{
            '{4'b0111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 31},
            '{4'b0100, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1},
            '{4'b0100, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 4},
            '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h4000_0000, 1},
            '{4'b0110, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 4},
            '{4'b0111, 32'h7000_0000, 32'h0000_0003, 32'h0E00_0000, 3},
            '{4'b0100, 32'h0000_FFFF, 32'h0000_0028, 32'h00FF_FF00, 8}
        };
        for (int i = 0; i < 7; i++) begin
            exp_lat = FAST ? 1 : v[i].lat;
            issue(v[i].op, v[i].a, v[i].b);
            lat     = 1;
            hold_ok = 1'b1;
            while (out_valid !== 1'b1 && lat < 40) begin
                if (busy !== 1'b1 || in_ready !== 1'b0) hold_ok = 1'b0;
                @(posedge clk);
                #1;
                lat++;
            end
            checks++; if (lat !== exp_lat) begin failures++; $display("FAIL shift%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
            checks++; if (result !== v[i].exp) begin failures++; $display("FAIL shift%0d_result: got %h expected %h", i, result, v[i].exp); end
            checks++; if (hold_ok !== 1'b1) begin failures++; $display("FAIL shift%0d_busy_ready: got %b expected 1", i, hold_ok); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL shift%0d_busy_done: got %b expected 0", i, busy); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [3];
        v = '{
            '{4'b1001, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1},
            '{4'b1010, 32'h1200_0000, 32'h0034_5678, 32'h1234_5678, 1},
            '{4'b1011, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 1}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            alu_op   = v[i].op;
            a        = v[i].a;
            b        = v[i].b;
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b%0d_valid: got %b expected 1", i, out_valid); end
            checks++; if (result !== v[i].exp) begin failures++; $display("FAIL b2b%0d_result: got %h expected %h", i, result, v[i].exp); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b%0d_in_ready: got %b expected 1", i, in_ready); end
        end
        out_ready = 1'b0;
        alu_op    = 4'b0000;
        a         = 32'h0000_0007;
        b         = 32'h0000_0008;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall%0d_in_ready: got %b expected 0", i, in_ready); end
            checks++; if (result !== 32'hFFFF_0000 || out_valid !== 1'b1) begin
                failures++; $display("FAIL stall%0d_hold: got %h/%b expected ffff0000/1", i, result, out_valid);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (result !== 32'h0000_000F || out_valid !== 1'b1) begin
            failures++; $display("FAIL stall_release: got %h/%b expected 0000000f/1", result, out_valid);
        end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        issue(4'b0100, 32'h0000_0001, 32'h0000_0014);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checks++; if (busy !== !FAST) begin failures++; $display("FAIL midshift_busy: got %b expected %b", busy, !FAST); end
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL abort_result: got %h expected 00000000", result); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset_idle: got %b/%b expected 0/1", out_valid, in_ready);
        end
        issue(4'b0000, 32'h0000_0002, 32'h0000_0002);
        checks++; if (result !== 32'h0000_0004 || out_valid !== 1'b1) begin
            failures++; $display("FAIL post_reset_add: got %h/%b expected 00000004/1", result, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_arith();
        test_shift();
        test_back_to_back();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
